// File: rtl/en_em_node_pkg.sv
// Shared definitions for the stochastic equality node: width helper,
// counter midpoint and the per-cycle operating mode.
package en_em_node_pkg;

  typedef enum logic [1:0] {
    MODE_FREEZE = 2'd0,
    MODE_INIT   = 2'd1,
    MODE_NORMAL = 2'd2
  } node_mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Counter reset/preload value: exactly undecided, DEC reads 1.
  function automatic int cnt_mid(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/en_em_node_edge_mem.sv
// Edge memory: shift register of recent regenerative bits, newest at index 0,
// read back at a random address while the edge is in hold state.
module en_em_node_edge_mem
  import en_em_node_pkg::*;
#(
  parameter int EM_S = 8,
  parameter int AW   = 3
) (
  input  logic          CLK_D2S,
  input  logic          nRESET,
  input  logic          WE,
  input  logic          D,
  input  logic [AW-1:0] SEL,
  output logic          OUT
);

  generate
    if (EM_S < 2 || (1 << AW) != EM_S || clog2(EM_S) != AW) begin : g_bad_depth
      $error("en_em_node_edge_mem: EM_S must be a power of two >= 2 and equal 2**AW");
    end
  endgenerate

  logic [EM_S-1:0] mem_reg;

  always_ff @(posedge CLK_D2S or negedge nRESET) begin
    if (!nRESET) begin
      mem_reg <= '0;
    end else if (WE) begin
      mem_reg <= {mem_reg[EM_S-2:0], D};
    end
  end

  assign OUT = mem_reg[SEL];

endmodule

// File: rtl/en_em_node.sv
// Stochastic equality (variable) node with one edge memory per PCN edge and a
// saturating up/down hard-decision counter.
module en_em_node
  import en_em_node_pkg::*;
#(
  parameter int DEG   = 4,
  parameter int EM_S  = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 4
) (
  input  logic              CLK_D2S,
  input  logic              nRESET,
  input  logic              INIT,
  input  logic              EN,
  input  logic              c,
  input  logic [DEG-1:0]    R,
  input  logic [DEG*AW-1:0] EM_SEL,
  output logic [DEG-1:0]    Q,
  output logic [DEG-1:0]    HOLD,
  output logic              DEC
);

  localparam int N_IN = DEG + 1;
  localparam int PW   = clog2(N_IN + 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(cnt_mid(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW:0]      N_VAL   = (PW + 1)'(N_IN);

  generate
    if (DEG < 2 || CNT_W < 2) begin : g_bad_params
      $error("en_em_node: DEG and CNT_W must both be >= 2");
    end
  endgenerate

  node_mode_e mode;
  logic [DEG-1:0]   a1;
  logic [DEG-1:0]   u;
  logic [DEG-1:0]   em_we;
  logic [DEG-1:0]   em_d;
  logic [DEG-1:0]   em_out;
  logic [DEG-1:0]   q_reg, q_next;
  logic [DEG-1:0]   hold_reg, hold_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PW-1:0]    pop;
  logic [PW:0]      pop_x2;

  always_comb begin
    mode = MODE_NORMAL;
    if (!EN) begin
      mode = MODE_FREEZE;
    end else if (INIT) begin
      mode = MODE_INIT;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEG; gi++) begin : g_edge
      // Forcing the own bit to the neutral value makes the AND extrinsic.
      localparam logic [DEG-1:0] SELF = DEG'(1) << gi;
      logic all_one;
      logic all_zero;

      assign all_one   = &(R | SELF);
      assign all_zero  = &(~R | SELF);
      assign a1[gi]    = c & all_one;
      assign u[gi]     = a1[gi] | (~c & all_zero);
      assign em_we[gi] = (mode == MODE_INIT) | ((mode == MODE_NORMAL) & u[gi]);
      assign em_d[gi]  = (mode == MODE_INIT) ? c : a1[gi];

      en_em_node_edge_mem #(
        .EM_S(EM_S),
        .AW  (AW)
      ) u_edge_mem (
        .CLK_D2S(CLK_D2S),
        .nRESET (nRESET),
        .WE     (em_we[gi]),
        .D      (em_d[gi]),
        .SEL    (EM_SEL[gi*AW +: AW]),
        .OUT    (em_out[gi])
      );
    end
  endgenerate

  always_comb begin
    pop = PW'(c);
    for (int i = 0; i < DEG; i++) begin
      pop = pop + PW'(R[i]);
    end
    pop_x2 = {pop, 1'b0};
  end

  always_comb begin
    q_next    = q_reg;
    hold_next = hold_reg;
    cnt_next  = cnt_reg;
    case (mode)
      MODE_INIT: begin
        q_next    = {DEG{c}};
        hold_next = '0;
        cnt_next  = CNT_MID;
      end
      MODE_NORMAL: begin
        // Edges that cannot regenerate replay a random past bit from their EM.
        for (int k = 0; k < DEG; k++) begin
          q_next[k]    = u[k] ? a1[k] : em_out[k];
          hold_next[k] = ~u[k];
        end
        if (pop_x2 > N_VAL && cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else if (pop_x2 < N_VAL && cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK_D2S or negedge nRESET) begin
    if (!nRESET) begin
      q_reg    <= '0;
      hold_reg <= '0;
      cnt_reg  <= CNT_MID;
    end else begin
      q_reg    <= q_next;
      hold_reg <= hold_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign Q    = q_reg;
  assign HOLD = hold_reg;
  assign DEC  = cnt_reg[CNT_W-1];

endmodule

// File: tb/tb_en_em_node.sv
// Randomised bench for en_em_node: a DEG=4/EM_S=8 instance and a DEG=6/EM_S=16
// instance share control inputs and are compared each cycle against a bit-list model.
module tb_en_em_node;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init;
  logic        en;
  logic        c;
  logic [3:0]  r0;
  logic [11:0] sel0;
  logic [5:0]  r1;
  logic [23:0] sel1;
  logic [3:0]  q0, hold0;
  logic [5:0]  q1, hold1;
  logic        dec0, dec1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edge memories as bit lists (index 0 newest), outputs, counter.
  bit         m_em[2][8][16];
  logic [7:0] m_q[2];
  logic [7:0] m_hold[2];
  int         m_cnt[2];

  always #5 clk = ~clk;

  en_em_node #(.DEG(4), .EM_S(8), .AW(3), .CNT_W(CW)) u_dut0 (
    .CLK_D2S(clk), .nRESET(rst_n), .INIT(init), .EN(en), .c(c),
    .R(r0), .EM_SEL(sel0), .Q(q0), .HOLD(hold0), .DEC(dec0)
  );

  en_em_node #(.DEG(6), .EM_S(16), .AW(4), .CNT_W(CW)) u_dut1 (
    .CLK_D2S(clk), .nRESET(rst_n), .INIT(init), .EN(en), .c(c),
    .R(r1), .EM_SEL(sel1), .Q(q1), .HOLD(hold1), .DEC(dec1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 8; k++) begin
        for (int i = 0; i < 16; i++) m_em[n][k][i] = 1'b0;
      end
      m_q[n]    = '0;
      m_hold[n] = '0;
      m_cnt[n]  = 1 << (CW - 1);
    end
  endtask

  task automatic em_push(input int n, input int k, input int ems, input bit v);
    for (int i = ems - 1; i > 0; i--) m_em[n][k][i] = m_em[n][k][i-1];
    m_em[n][k][0] = v;
  endtask

  task automatic model_step(input int n, input int deg, input int ems, input int aw,
                            input logic [7:0] r, input logic [31:0] sel);
    int ones_r;
    int ones_ex;
    int p;
    int s;
    bit a1;
    bit a0;
    if (!en) return;
    if (init) begin
      for (int k = 0; k < deg; k++) begin
        em_push(n, k, ems, c);
        m_q[n][k]    = c;
        m_hold[n][k] = 1'b0;
      end
      m_cnt[n] = 1 << (CW - 1);
      return;
    end
    ones_r = 0;
    for (int k = 0; k < deg; k++) ones_r += int'(r[k]);
    for (int k = 0; k < deg; k++) begin
      ones_ex = ones_r - int'(r[k]);
      a1 = c && (ones_ex == deg - 1);
      a0 = !c && (ones_ex == 0);
      if (a1 || a0) begin
        m_q[n][k]    = a1;
        m_hold[n][k] = 1'b0;
        em_push(n, k, ems, a1);
      end else begin
        s = int'((sel >> (k * aw)) & ((32'd1 << aw) - 1));
        m_q[n][k]    = m_em[n][k][s];
        m_hold[n][k] = 1'b1;
      end
    end
    p = ones_r + int'(c);
    if (2 * p > deg + 1) begin
      if (m_cnt[n] < (1 << CW) - 1) m_cnt[n]++;
    end else if (2 * p < deg + 1) begin
      if (m_cnt[n] > 0) m_cnt[n]--;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_q0"},    32'(q0),    32'(m_q[0][3:0]));
    check({tag, "_hold0"}, 32'(hold0), 32'(m_hold[0][3:0]));
    check({tag, "_dec0"},  32'(dec0),  32'(m_cnt[0] >= (1 << (CW - 1))));
    check({tag, "_q1"},    32'(q1),    32'(m_q[1][5:0]));
    check({tag, "_hold1"}, 32'(hold1), 32'(m_hold[1][5:0]));
    check({tag, "_dec1"},  32'(dec1),  32'(m_cnt[1] >= (1 << (CW - 1))));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      model_step(0, 4, 8, 3, {4'b0, r0}, {20'b0, sel0});
      model_step(1, 6, 16, 4, {2'b0, r1}, {8'b0, sel1});
    end
    #1;
    compare_all(tag);
  endtask

  // Biased PCN bits so regenerative (all-agree) cases occur often enough.
  function automatic logic [7:0] gen_r(input int deg, input logic cv);
    logic [7:0] v;
    case ($urandom % 4)
      1: v = cv ? 8'hFF : 8'h00;
      2: v = (cv ? 8'hFF : 8'h00) ^ (8'd1 << $urandom_range(0, deg - 1));
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  task automatic randomize_inputs();
    logic [7:0] t;
    c    = 1'($urandom);
    t    = gen_r(4, c);
    r0   = t[3:0];
    t    = gen_r(6, c);
    r1   = t[5:0];
    sel0 = 12'($urandom);
    sel1 = 24'($urandom);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_q0"},    32'(q0),    32'h0);
    check({tag, "_hold0"}, 32'(hold0), 32'h0);
    check({tag, "_dec0"},  32'(dec0),  32'h1);
    compare_all(tag);
    @(posedge clk);
    #1;
    compare_all({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    init  = 1'b0;
    en    = 1'b0;
    c     = 1'b0;
    r0    = '0;
    r1    = '0;
    sel0  = '0;
    sel1  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_q0",    32'(q0),    32'h0);
    check("rst_hold0", 32'(hold0), 32'h0);
    check("rst_dec0",  32'(dec0),  32'h1);
    check("rst_dec1",  32'(dec1),  32'h1);
    rst_n = 1'b1;

    // Initialisation: preload all EMs with ones.
    en   = 1'b1;
    init = 1'b1;
    c    = 1'b1;
    repeat (8) tick("t2_init");
    $display("[TB] init done q0=%b hold0=%b", q0, hold0);

    // Disagreeing PCN bits with c=0: every edge replays its EM.
    init = 1'b0;
    c    = 1'b0;
    r0   = 4'b0101;
    r1   = 6'b010101;
    sel0 = 12'($urandom);
    sel1 = 24'($urandom);
    tick("t2_hold");
    check("t2_q0_all1",    32'(q0),    32'hF);
    check("t2_hold0_all1", 32'(hold0), 32'hF);
    check("t2_hold1_all1", 32'(hold1), 32'h3F);

    // Only edge 0 sees an all-ones extrinsic set.
    c  = 1'b1;
    r0 = 4'b1110;
    r1 = 6'b111110;
    tick("t3");
    check("t3_q0",    32'(q0),    32'hF);
    check("t3_hold0", 32'(hold0), 32'hE);
    check("t3_hold1", 32'(hold1), 32'h3E);

    // Enable gating with toggling inputs.
    en = 1'b0;
    repeat (5) begin
      randomize_inputs();
      init = 1'($urandom);
      tick("t4_freeze");
    end
    init = 1'b0;
    en   = 1'b1;

    // Counter saturation in both directions.
    c  = 1'b1;
    r0 = 4'hF;
    r1 = 6'h3F;
    repeat (20) tick("t5_up");
    check("t5_dec_high", 32'(dec0), 32'h1);
    c  = 1'b0;
    r0 = 4'h0;
    r1 = 6'h0;
    repeat (20) tick("t5_down");
    check("t5_dec_low", 32'(dec0), 32'h0);
    c  = 1'b1;
    r0 = 4'hF;
    r1 = 6'h3F;
    repeat (7) tick("t5_climb");
    check("t5_no_wrap", 32'(dec0), 32'h0);
    tick("t5_mid");
    check("t5_mid_dec", 32'(dec0), 32'h1);

    // Mid-stream asynchronous reset, then normal operation on cleared EMs.
    randomize_inputs();
    repeat (3) tick("t1_pre");
    async_reset("t1_rst");
    randomize_inputs();
    r0 = 4'b0101;
    c  = 1'b0;
    tick("t1_post");
    check("t1_em_zero", 32'(q0), 32'h0);

    // Long randomised run.
    for (int i = 0; i < 10000; i++) begin
      en   = ($urandom % 8) != 0;
      init = ($urandom % 64) == 0;
      randomize_inputs();
      tick("t6");
      if (i == 5000) async_reset("t6_rst");
    end
    $display("[TB] random phase done q1=%b hold1=%b dec1=%b", q1, hold1, dec1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
